// File: rtl/ramp_checker_multilane.sv
// Test-ramp checker for NLANES parallel WIDTH-bit samples: verifies per-lane continuity
// and lane-to-lane stepping, tracks acquire/lock, counts good/bad words with a snapshot.
module ramp_checker_multilane #(
  parameter int NLANES    = 8,
  parameter int WIDTH     = 10,
  parameter int CNT_W     = 64,
  parameter int LOCK_GOOD = 4,
  parameter int LOSS_BAD  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NLANES*WIDTH-1:0]   din,
  input  logic                      din_valid,
  input  logic [WIDTH-1:0]          serial_step,
  input  logic [WIDTH-1:0]          lane_step,
  input  logic                      clr,
  input  logic                      snap,
  output logic [CNT_W-1:0]          ok_cnt,
  output logic [CNT_W-1:0]          err_cnt,
  output logic [NLANES-1:0]         lane_err,
  output logic                      locked,
  output logic                      lock_lost
);

  localparam int RUN_MAX = (LOCK_GOOD > LOSS_BAD) ? LOCK_GOOD : LOSS_BAD;
  localparam int RUN_W   = $clog2(RUN_MAX + 1);

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);
  localparam logic [RUN_W-1:0] LOCK_LAST = RUN_W'(LOCK_GOOD - 1);
  localparam logic [RUN_W-1:0] LOSS_LAST = RUN_W'(LOSS_BAD - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [1:0]              state_r, state_nxt_s;
  logic [RUN_W-1:0]        run_r, run_nxt_s;
  logic [RUN_W-1:0]        bad_run_r, bad_run_nxt_s;
  logic [NLANES*WIDTH-1:0] prev_r;
  logic [CNT_W-1:0]        ok_live_r, err_live_r, ok_cnt_r, err_cnt_r;
  logic [NLANES-1:0]       lane_err_r, lane_err_nxt_s;
  logic                    locked_r, lock_lost_r;
  logic                    ok_inc_s, err_inc_s, lost_set_s;
  logic [NLANES-1:0]       lane_bad_s;
  logic                    good_s;

  // Serial check against the previous valid word, lane check against the lane below.
  for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
    logic [WIDTH-1:0] ser_sum_s;
    logic             ser_ok_s, par_ok_s;
    assign ser_sum_s = prev_r[gi*WIDTH +: WIDTH] + serial_step;
    assign ser_ok_s  = (din[gi*WIDTH +: WIDTH] == ser_sum_s);
    if (gi == 0) begin : g_first
      assign par_ok_s = 1'b1;
    end else begin : g_rest
      logic [WIDTH-1:0] par_sum_s;
      assign par_sum_s = din[(gi-1)*WIDTH +: WIDTH] + lane_step;
      assign par_ok_s  = (din[gi*WIDTH +: WIDTH] == par_sum_s);
    end
    assign lane_bad_s[gi] = ~(ser_ok_s & par_ok_s);
  end

  assign good_s = ~(|lane_bad_s);

  // Acquire/lock state machine; advances only on valid words.
  always_comb begin
    state_nxt_s    = state_r;
    run_nxt_s      = run_r;
    bad_run_nxt_s  = bad_run_r;
    lane_err_nxt_s = lane_err_r;
    ok_inc_s       = 1'b0;
    err_inc_s      = 1'b0;
    lost_set_s     = 1'b0;
    if (din_valid) begin
      case (state_r)
        ST_EMPTY: begin
          state_nxt_s   = ST_ACQUIRE;
          run_nxt_s     = '0;
          bad_run_nxt_s = '0;
        end
        ST_ACQUIRE: begin
          if (good_s) begin
            if (run_r == LOCK_LAST) begin
              state_nxt_s   = ST_LOCKED;
              run_nxt_s     = '0;
              bad_run_nxt_s = '0;
            end else begin
              run_nxt_s = run_r + RUN_ONE;
            end
          end else begin
            run_nxt_s = '0;
          end
        end
        ST_LOCKED: begin
          if (good_s) begin
            ok_inc_s      = 1'b1;
            bad_run_nxt_s = '0;
          end else begin
            err_inc_s      = 1'b1;
            lane_err_nxt_s = lane_err_r | lane_bad_s;
            if (bad_run_r == LOSS_LAST) begin
              state_nxt_s   = ST_ACQUIRE;
              run_nxt_s     = '0;
              bad_run_nxt_s = '0;
              lost_set_s    = 1'b1;
            end else begin
              bad_run_nxt_s = bad_run_r + RUN_ONE;
            end
          end
        end
        default: begin
          state_nxt_s   = ST_EMPTY;
          run_nxt_s     = '0;
          bad_run_nxt_s = '0;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Live state, counters and sticky flags; clr discards any word in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_r     <= ST_EMPTY;
      run_r       <= '0;
      bad_run_r   <= '0;
      prev_r      <= '0;
      ok_live_r   <= '0;
      err_live_r  <= '0;
      lane_err_r  <= '0;
      locked_r    <= 1'b0;
      lock_lost_r <= 1'b0;
    end else if (din_valid) begin
      state_r     <= state_nxt_s;
      run_r       <= run_nxt_s;
      bad_run_r   <= bad_run_nxt_s;
      prev_r      <= din;
      lane_err_r  <= lane_err_nxt_s;
      locked_r    <= (state_nxt_s == ST_LOCKED);
      lock_lost_r <= lock_lost_r | lost_set_s;
      if (ok_inc_s) begin
        ok_live_r <= sat_inc(ok_live_r);
      end
      if (err_inc_s) begin
        err_live_r <= sat_inc(err_live_r);
      end
    end
  end

  // Snapshot registers; snap wins over clr so the pre-clear counts are captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      ok_cnt_r  <= '0;
      err_cnt_r <= '0;
    end else if (snap) begin
      ok_cnt_r  <= ok_live_r;
      err_cnt_r <= err_live_r;
    end else if (clr) begin
      ok_cnt_r  <= '0;
      err_cnt_r <= '0;
    end
  end

  assign ok_cnt    = ok_cnt_r;
  assign err_cnt   = err_cnt_r;
  assign lane_err  = lane_err_r;
  assign locked    = locked_r;
  assign lock_lost = lock_lost_r;

endmodule

// File: tb/tb_ramp_checker_multilane.sv
// Directed bench for ramp_checker_multilane: a full-width instance plus a CNT_W=4
// instance on the same stimulus to observe counter saturation.
module tb_ramp_checker_multilane;

  logic        clk = 1'b0;
  logic        rst;
  logic [79:0] din;
  logic        din_valid;
  logic [9:0]  serial_step, lane_step;
  logic        clr, snap;
  logic [63:0] ok_cnt, err_cnt;
  logic [7:0]  lane_err;
  logic        locked, lock_lost;
  logic [3:0]  ok_cnt4, err_cnt4;
  logic [7:0]  lane_err4;
  logic        locked4, lock_lost4;

  int checks = 0;
  int errors = 0;
  int base   = 4;

  always #5 clk = ~clk;

  ramp_checker_multilane u_dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .serial_step(serial_step), .lane_step(lane_step), .clr(clr), .snap(snap),
    .ok_cnt(ok_cnt), .err_cnt(err_cnt), .lane_err(lane_err),
    .locked(locked), .lock_lost(lock_lost)
  );

  ramp_checker_multilane #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .serial_step(serial_step), .lane_step(lane_step), .clr(clr), .snap(snap),
    .ok_cnt(ok_cnt4), .err_cnt(err_cnt4), .lane_err(lane_err4),
    .locked(locked4), .lock_lost(lock_lost4)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [79:0] ramp(input int b);
    logic [79:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i*10 +: 10] = 10'((b + i) & 1023);
    end
    return r;
  endfunction

  // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic v, input logic [79:0] w, input logic s, input logic c);
    din_valid = v;
    din       = w;
    snap      = s;
    clr       = c;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    snap      = 1'b0;
    clr       = 1'b0;
  endtask

  task automatic good_word();
    cyc(1'b1, ramp(base), 1'b0, 1'b0);
    base += 8;
  endtask

  initial begin
    logic [79:0] w;
    int nv;
    rst = 1'b1; din = 80'd0; din_valid = 1'b0; clr = 1'b0; snap = 1'b0;
    serial_step = 10'd8; lane_step = 10'd1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_locked", {63'd0, locked}, 64'd0);
    chk("rst_ok", ok_cnt, 64'd0);
    chk("rst_err", err_cnt, 64'd0);
    chk("rst_lane_err", {56'd0, lane_err}, 64'd0);
    chk("rst_lock_lost", {63'd0, lock_lost}, 64'd0);
    rst = 1'b0;

    // Clean ramp, 20 words; lock after word 5
    for (int k = 1; k <= 20; k++) begin
      good_word();
      if (k == 4) chk("t1_unlocked_w4", {63'd0, locked}, 64'd0);
      if (k == 5) chk("t1_locked_w5", {63'd0, locked}, 64'd1);
    end
    cyc(1'b0, 80'd0, 1'b1, 1'b0);
    chk("t1_ok", ok_cnt, 64'd15);
    chk("t1_err", err_cnt, 64'd0);
    chk("t1_lane_err", {56'd0, lane_err}, 64'd0);
    chk("t1_ok4", {60'd0, ok_cnt4}, 64'd15);

    // 120 more valid words through the 1023->0 wrap with random gaps
    nv = 0;
    for (int it = 0; it < 2000 && nv < 120; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        good_word();
        nv++;
      end else begin
        cyc(1'b0, ~ramp(base), 1'b0, 1'b0);
      end
    end
    cyc(1'b0, 80'd0, 1'b1, 1'b0);
    chk("t2_ok", ok_cnt, 64'd135);
    chk("t2_err", err_cnt, 64'd0);
    chk("t2_lane_err", {56'd0, lane_err}, 64'd0);
    chk("t2_locked", {63'd0, locked}, 64'd1);
    chk("t2_ok4_sat", {60'd0, ok_cnt4}, 64'd15);

    // Corrupt lane 3: flags lane 3 (serial+lane) and lane 4 (lane check vs lane 3)
    w = ramp(base);
    w[39:30] = w[39:30] ^ 10'h155;
    cyc(1'b1, w, 1'b0, 1'b0);
    base += 8;
    chk("t3_lane_err", {56'd0, lane_err}, 64'h18);
    chk("t3_locked", {63'd0, locked}, 64'd1);
    repeat (3) good_word();
    cyc(1'b0, 80'd0, 1'b1, 1'b0);
    chk("t3_err", err_cnt, 64'd2);
    chk("t3_ok", ok_cnt, 64'd137);
    chk("t3_lane_err_hold", {56'd0, lane_err}, 64'h18);
    chk("t3_locked_hold", {63'd0, locked}, 64'd1);

    // Four bad words force loss of lock
    for (int k = 1; k <= 4; k++) begin
      cyc(1'b1, ~ramp(base), 1'b0, 1'b0);
      base += 8;
      if (k == 3) chk("t4_locked_b3", {63'd0, locked}, 64'd1);
    end
    chk("t4_unlocked", {63'd0, locked}, 64'd0);
    chk("t4_lock_lost", {63'd0, lock_lost}, 64'd1);
    // First resumed word fails its serial check in ACQUIRE, so relock after 5
    for (int k = 1; k <= 5; k++) begin
      good_word();
      if (k == 4) chk("t4_unlocked_r4", {63'd0, locked}, 64'd0);
    end
    chk("t4_relocked", {63'd0, locked}, 64'd1);
    cyc(1'b0, 80'd0, 1'b1, 1'b0);
    chk("t4_err", err_cnt, 64'd6);
    chk("t4_ok", ok_cnt, 64'd137);
    chk("t4_lane_err", {56'd0, lane_err}, 64'hFF);
    chk("t4_err4", {60'd0, err_cnt4}, 64'd6);

    // snap+clr with a valid word: snapshot keeps prior counts, word discarded
    cyc(1'b1, ramp(base), 1'b1, 1'b1);
    base += 8;
    chk("t5_ok_snap", ok_cnt, 64'd137);
    chk("t5_err_snap", err_cnt, 64'd6);
    chk("t5_locked", {63'd0, locked}, 64'd0);
    chk("t5_lane_err", {56'd0, lane_err}, 64'd0);
    chk("t5_lock_lost", {63'd0, lock_lost}, 64'd0);
    cyc(1'b0, 80'd0, 1'b1, 1'b0);
    chk("t5_ok_zero", ok_cnt, 64'd0);
    chk("t5_err_zero", err_cnt, 64'd0);
    for (int k = 1; k <= 5; k++) begin
      good_word();
      if (k == 4) chk("t5_unlocked_w4", {63'd0, locked}, 64'd0);
    end
    chk("t5_relocked", {63'd0, locked}, 64'd1);

    // Reset while LOCKED
    repeat (3) good_word();
    cyc(1'b0, 80'd0, 1'b1, 1'b0);
    chk("t6_ok_pre", ok_cnt, 64'd3);
    rst = 1'b1;
    good_word();
    rst = 1'b0;
    chk("t6_locked", {63'd0, locked}, 64'd0);
    chk("t6_ok", ok_cnt, 64'd0);
    chk("t6_err", err_cnt, 64'd0);
    chk("t6_lane_err", {56'd0, lane_err}, 64'd0);
    chk("t6_lock_lost", {63'd0, lock_lost}, 64'd0);
    chk("t6_ok4", {60'd0, ok_cnt4}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
